// File: rtl/regfile_writeback_pkg.sv
// Shared constants, types and the pending-mask helper for the decode-stage
// register writeback slice.
package regfile_writeback_pkg;

  localparam int NUM_GPR     = 32;
  localparam int GPR_ADDR_W  = 5;
  localparam int CTRL_WB_BIT = 31;

  typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;
  typedef logic [NUM_GPR-1:0]    gpr_mask_t;

  // r0 never owns a pending bit, so the mask stays clear for it even when enabled.
  function automatic gpr_mask_t onehot32(input gpr_addr_t addr, input logic en);
    gpr_mask_t mask;
    mask = '0;
    if (en && (addr != '0)) begin
      mask[addr] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// EX-stage inputs, debug read port and IDECODE-facing outputs of the writeback
// block, bundled so the decode side can connect with a single port.
interface regfile_writeback_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  import regfile_writeback_pkg::*;

  logic                      ExWe;
  gpr_addr_t                 ExDst;
  logic [DATA_W-1:0]         ExResult;
  gpr_addr_t                 DbgAddr;
  logic [DATA_W-1:0]         DbgData;
  logic [NUM_GPR*DATA_W-1:0] Regfile_flat;
  gpr_mask_t                 RdEx;
  gpr_mask_t                 RdWb;
  logic [CNT_W-1:0]          WbCount;

  modport master (
    output ExWe, ExDst, ExResult, DbgAddr,
    input  DbgData, Regfile_flat, RdEx, RdWb, WbCount
  );

  modport slave (
    input  ExWe, ExDst, ExResult, DbgAddr,
    output DbgData, Regfile_flat, RdEx, RdWb, WbCount
  );

endinterface

// File: rtl/regfile_writeback_gpr_array.sv
// 32-entry GPR storage: one synchronous write port, r0 hardwired to zero,
// a flattened image for IDECODE and one combinational debug read port.
module gpr_array
  import regfile_writeback_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      we,
  input  gpr_addr_t                 waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  gpr_addr_t                 raddr,
  output logic [DATA_W-1:0]         rdata,
  output logic [NUM_GPR*DATA_W-1:0] flat
);

  logic [DATA_W-1:0] regs [NUM_GPR];

  // r0 is never written, so it keeps its reset value of zero forever.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_GPR; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];

  // GPR[0] lands in the most significant slice, GPR[31] in the least.
  for (genvar g = 0; g < NUM_GPR; g++) begin : g_flat
    assign flat[(NUM_GPR-1-g)*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback end of the decode-stage register interface: one-entry WB pipeline
// register, commit into the GPR array, pending-write masks and commit counter.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input logic                Clk,
  input logic                Reset,
  regfile_writeback_if.slave bus
);

  logic              wb_we;
  gpr_addr_t         wb_dst;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  wb_count;

  // Writes to r0 are filtered here so they never commit, count or raise RdWb.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wb_we    <= 1'b0;
      wb_dst   <= '0;
      wb_data  <= '0;
      wb_count <= '0;
    end else begin
      wb_we   <= bus.ExWe && (bus.ExDst != '0);
      wb_dst  <= bus.ExDst;
      wb_data <= bus.ExResult;
      if (wb_we) begin
        wb_count <= wb_count + CNT_W'(1);
      end
    end
  end

  gpr_array #(
    .DATA_W (DATA_W)
  ) u_gpr_array (
    .Clk   (Clk),
    .Reset (Reset),
    .we    (wb_we),
    .waddr (wb_dst),
    .wdata (wb_data),
    .raddr (bus.DbgAddr),
    .rdata (bus.DbgData),
    .flat  (bus.Regfile_flat)
  );

  assign bus.RdEx    = onehot32(bus.ExDst, bus.ExWe);
  assign bus.RdWb    = onehot32(wb_dst, wb_we);
  assign bus.WbCount = wb_count;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: an architectural model of the GPR
// file and pending writes is compared against the DUT on every negedge.
`timescale 1ns/1ps
module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  regfile_writeback_if #(.DATA_W(32), .CNT_W(32)) rif ();

  regfile_writeback #(.DATA_W(32), .CNT_W(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (rif)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  // Model: architectural register contents plus the one instruction awaiting commit.
  logic [31:0] mGpr [NUM_GPR];
  bit          mPendValid;
  int          mPendDst;
  logic [31:0] mPendData;
  logic [31:0] mCount;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] gprOf(input int idx);
    return rif.Regfile_flat[(NUM_GPR-1-idx)*32 +: 32];
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_GPR; i++) mGpr[i] = 32'h0;
      mPendValid = 1'b0;
      mCount     = 32'h0;
    end else begin
      if (mPendValid) begin
        mGpr[mPendDst] = mPendData;
        mCount         = mCount + 32'd1;
      end
      mPendValid = (rif.ExWe === 1'b1) && (rif.ExDst != 5'd0);
      mPendDst   = int'(rif.ExDst);
      mPendData  = rif.ExResult;
    end
  end

  always @(negedge Clk) begin
    if (checkEn) begin
      logic [31:0] wantEx;
      logic [31:0] wantWb;
      wantEx = ((rif.ExWe === 1'b1) && (rif.ExDst != 5'd0)) ? (32'd1 << rif.ExDst) : 32'd0;
      wantWb = mPendValid ? (32'd1 << mPendDst) : 32'd0;
      checkOutput("cmp_rdex", rif.RdEx, wantEx);
      checkOutput("cmp_rdwb", rif.RdWb, wantWb);
      checkOutput("cmp_wbcount", rif.WbCount, mCount);
      checkOutput($sformatf("cmp_dbg_r%0d", rif.DbgAddr), rif.DbgData, mGpr[rif.DbgAddr]);
      for (int i = 0; i < NUM_GPR; i++) begin
        checkOutput($sformatf("cmp_flat_r%0d", i), gprOf(i), mGpr[i]);
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [4:0] dst,
                               input logic [31:0] res, input logic rst);
    @(posedge Clk);
    #1;
    rif.ExWe     = we;
    rif.ExDst    = dst;
    rif.ExResult = res;
    rif.DbgAddr  = 5'($urandom_range(0, 31));
    Reset        = rst;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'hBAD0_0000 + 32'($urandom_range(0, 255)), 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rif.ExWe     = 1'b0;
    rif.ExDst    = 5'd0;
    rif.ExResult = 32'h0;
    rif.DbgAddr  = 5'd0;

    // Reset held across several edges while every debug address is read back.
    @(posedge Clk);
    #1;
    checkEn = 1'b1;
    for (int a = 0; a < NUM_GPR; a++) begin
      rif.DbgAddr = 5'(a);
      #1;
      checkOutput($sformatf("rst_dbg_r%0d", a), rif.DbgData, 32'h0);
    end
    checkOutput("rst_flat_hi", rif.Regfile_flat[1023:992], 32'h0);
    checkOutput("rst_flat_or", {31'h0, |rif.Regfile_flat}, 32'h0);
    checkOutput("rst_rdex", rif.RdEx, 32'h0);
    checkOutput("rst_rdwb", rif.RdWb, 32'h0);
    checkOutput("rst_wbcount", rif.WbCount, 32'h0);
    idle();

    // Single write to r5.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    @(negedge Clk);
    checkOutput("w5_rdex_t", rif.RdEx, 32'h20);
    idle();
    @(negedge Clk);
    checkOutput("w5_rdwb_t1", rif.RdWb, 32'h20);
    checkOutput("w5_gpr_t1", rif.Regfile_flat[863:832], 32'h0);
    idle();
    @(negedge Clk);
    checkOutput("w5_gpr_t2", rif.Regfile_flat[863:832], 32'hDEADBEEF);
    checkOutput("w5_rdex_t2", rif.RdEx, 32'h0);
    checkOutput("w5_rdwb_t2", rif.RdWb, 32'h0);
    checkOutput("w5_count_t2", rif.WbCount, 32'd1);
    checkOutput("model_gpr5", mGpr[5], 32'hDEADBEEF);
    checkOutput("model_count1", mCount, 32'd1);

    // r0 write is dropped.
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0);
    @(negedge Clk);
    checkOutput("r0_rdex", rif.RdEx, 32'h0);
    idle();
    @(negedge Clk);
    checkOutput("r0_rdwb", rif.RdWb, 32'h0);
    idle();
    @(negedge Clk);
    checkOutput("r0_gpr", rif.Regfile_flat[1023:992], 32'h0);
    checkOutput("r0_count", rif.WbCount, 32'd1);

    // Back-to-back writes to r7, last one wins.
    applyStimulus(1'b1, 5'd7, 32'd11, 1'b0);
    applyStimulus(1'b1, 5'd7, 32'd22, 1'b0);
    @(negedge Clk);
    checkOutput("b2b_rdex", rif.RdEx, 32'h80);
    checkOutput("b2b_rdwb", rif.RdWb, 32'h80);
    idle();
    @(negedge Clk);
    checkOutput("b2b_mid_gpr7", gprOf(7), 32'd11);
    idle();
    @(negedge Clk);
    checkOutput("b2b_gpr7", gprOf(7), 32'd22);
    checkOutput("b2b_count", rif.WbCount, 32'd3);

    // Sweep every writable register, interleaved with one bubble carrying junk.
    for (int i = 1; i < NUM_GPR; i++) begin
      applyStimulus(1'b1, 5'(i), 32'h1000_0000 + 32'(i), 1'b0);
      if (i == 16) applyStimulus(1'b0, 5'd16, 32'hFFFF_FFFF, 1'b0);
    end
    idle();
    idle();
    @(negedge Clk);
    checkOutput("sweep_gpr31", gprOf(31), 32'h1000_001F);
    checkOutput("sweep_gpr16", gprOf(16), 32'h1000_0010);
    checkOutput("sweep_count", rif.WbCount, 32'd34);

    // Reset while an r9 write sits in WB: nothing commits.
    applyStimulus(1'b1, 5'd9, 32'd99, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1);
    @(negedge Clk);
    checkOutput("rst_mid_rdwb_pre", rif.RdWb, 32'h200);
    idle();
    @(negedge Clk);
    checkOutput("rst_mid_gpr9", gprOf(9), 32'h0);
    checkOutput("rst_mid_rdwb", rif.RdWb, 32'h0);
    checkOutput("rst_mid_count", rif.WbCount, 32'h0);
    checkOutput("rst_mid_gpr31", gprOf(31), 32'h0);

    // Counter wrap from all-ones.
    idle();
    #1;
    force dut.wb_count = 32'hFFFF_FFFF;
    mCount = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count;
    @(negedge Clk);
    checkOutput("wrap_preload", rif.WbCount, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0);
    idle();
    idle();
    @(negedge Clk);
    checkOutput("wrap_count", rif.WbCount, 32'h0);
    checkOutput("wrap_gpr3", gprOf(3), 32'hA5A5_A5A5);

    idle();
    idle();
    @(negedge Clk);
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
